// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master)
// and the instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the program counter, issues instruction fetches and
// applies jump/branch redirects, with a fetch-timeout watchdog.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [31:0]           jump_target,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  pc_sequencer_if.master        imem,
  output logic [31:0]           pc_out,
  output logic [31:0]           fetched_pc,
  output logic                  instr_valid,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  localparam int unsigned    WCW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t         state_r;
  logic [31:0]    pc_r;
  logic [31:0]    fetched_r;
  logic [31:0]    pend_tgt_r;
  logic           pend_r;
  logic           req_r;
  logic           valid_r;
  logic           mis_r;
  logic           to_r;
  logic [WCW-1:0] wait_r;

  logic           redirect_s;
  logic           misaligned_s;
  logic [31:0]    raw_target_s;
  logic [WCW-1:0] wait_inc_s;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect selection (jump beats branch) and wait-counter increment
  always_comb begin
    redirect_s   = 1'b0;
    raw_target_s = 32'h0000_0000;
    if (jump) begin
      redirect_s   = 1'b1;
      raw_target_s = jump_target;
    end else if (branch_taken) begin
      redirect_s   = 1'b1;
      raw_target_s = branch_target;
    end else begin
      redirect_s   = 1'b0;
      raw_target_s = 32'h0000_0000;
    end
    misaligned_s = redirect_s && (raw_target_s[1:0] != 2'b00);
    wait_inc_s   = wait_r + WCW'(1);
  end

  // Fetch sequencing state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      fetched_r  <= 32'h0000_0000;
      pend_tgt_r <= 32'h0000_0000;
      pend_r     <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      mis_r      <= 1'b0;
      to_r       <= 1'b0;
      wait_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= REQ;
          req_r   <= 1'b1;
          wait_r  <= '0;
          valid_r <= 1'b0;
          mis_r   <= 1'b0;
        end
        REQ: begin
          if (imem.imem_ack) begin
            wait_r <= '0;
            pend_r <= 1'b0;
            mis_r  <= misaligned_s;
            // A redirect seen now is newer than any pending one
            if (redirect_s) begin
              pc_r    <= align_word(raw_target_s);
              valid_r <= 1'b0;
            end else if (pend_r) begin
              pc_r    <= pend_tgt_r;
              valid_r <= 1'b0;
            end else begin
              pc_r      <= pc_r + 32'd4;
              fetched_r <= pc_r;
              valid_r   <= 1'b1;
            end
            if (stall) begin
              state_r <= HOLD;
              req_r   <= 1'b0;
            end else begin
              state_r <= REQ;
              req_r   <= 1'b1;
            end
          end else if (wait_inc_s == WAIT_LIMIT) begin
            state_r <= ERR;
            to_r    <= 1'b1;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            mis_r   <= 1'b0;
            wait_r  <= wait_inc_s;
          end else begin
            wait_r  <= wait_inc_s;
            valid_r <= 1'b0;
            mis_r   <= misaligned_s;
            if (redirect_s) begin
              pend_r     <= 1'b1;
              pend_tgt_r <= align_word(raw_target_s);
            end
          end
        end
        HOLD: begin
          valid_r <= 1'b0;
          mis_r   <= misaligned_s;
          if (redirect_s) begin
            pc_r <= align_word(raw_target_s);
          end
          if (!stall) begin
            state_r <= REQ;
            req_r   <= 1'b1;
            wait_r  <= '0;
          end
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          mis_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign pc_out         = pc_r;
  assign fetched_pc     = fetched_r;
  assign instr_valid    = valid_r;
  assign misalign_err   = mis_r;
  assign timeout_err    = to_r;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, is the maximum number of REQ-state cycles without imem_ack before the sequencer declares a timeout.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  pipeline hold request.
REQ-006 jump  input  1  unconditional redirect request.
REQ-007 jump_target  input  32  jump destination.
REQ-008 branch_taken  input  1  taken-branch redirect request.
REQ-009 branch_target  input  32  branch destination.
REQ-010 imem_ack  input  1  instruction memory accepts the current imem_addr.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  32  fetch address; equals pc_out.
REQ-013 pc_out  output  32  current PC register; this block owns the PC.
REQ-014 fetched_pc  output  32  address of the most recent accepted, non-discarded fetch.
REQ-015 instr_valid  output  1  one-cycle pulse; fetched_pc is valid for decode.
REQ-016 misalign_err  output  1  one-cycle pulse on a misaligned redirect.
REQ-017 timeout_err  output  1  sticky fetch-timeout flag.

Function
REQ-018 States are IDLE, REQ, HOLD and ERR; all outputs are registered.
REQ-019 IDLE lasts exactly one cycle with imem_req=0, then moves to REQ.
REQ-020 In REQ, imem_req=1 and imem_addr=pc_out.
REQ-021 In REQ, imem_addr shall not change until imem_ack is sampled high.
REQ-022 On an ack edge, the sequencer sets fetched_pc<=pc_out and instr_valid<=1, and loads pc_out with the next PC.
REQ-023 The next PC after an ack is the redirect target if a redirect is pending, or present in that cycle; otherwise it is pc_out+4.
REQ-024 If a redirect applies at the ack edge, the acked fetch is discarded: instr_valid stays 0 and fetched_pc is unchanged.
REQ-025 After an ack, the state stays REQ with back-to-back requests (new address next cycle) when stall=0; it moves to HOLD when stall=1.
REQ-026 Redirect priority: jump over branch_taken within a cycle.
REQ-027 A redirect in REQ without ack is latched as pending, and a later redirect overwrites it (latest wins).
REQ-028 The pending redirect clears when it is consumed at the ack edge.
REQ-029 stall asserted during REQ does not abort the outstanding request; the transition to HOLD occurs only after ack.
REQ-030 In HOLD, imem_req=0 and instr_valid=0.
REQ-031 A redirect in HOLD loads pc_out directly on that edge.
REQ-032 HOLD moves to REQ on the first cycle stall=0.
REQ-033 PC increment wraps modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-034 A redirect target with target[1:0]!=0 is used with bits [1:0] cleared, and misalign_err pulses one cycle on the edge the redirect is accepted.
REQ-035 The wait counter resets on each ack and on each entry to REQ, and increments each REQ cycle without ack.
REQ-036 When the wait counter reaches MAX_WAIT, timeout_err<=1, the state moves to ERR, and imem_req<=0.
REQ-037 ERR holds all outputs and ignores all inputs except rst.

Reset
REQ-038 rst=1 at any edge, including mid-request, forces: state IDLE; pc_out=imem_addr=RESET_PC; fetched_pc=0; imem_req=0; instr_valid=0; misalign_err=0; timeout_err=0; pending redirect and wait counter cleared.
REQ-039 rst overrides every other input in the same cycle.
REQ-040 An outstanding request is abandoned on reset, and an imem_ack arriving in the reset cycle is ignored.

Verification
REQ-041 Reset then imem_ack tied 1 -> imem_addr sequence 0,4,8,C on consecutive cycles; instr_valid=1 each cycle after the first ack; fetched_pc lags imem_addr by one cycle.
REQ-042 imem_ack held 0 for 3 cycles while branch_taken=1 with branch_target=0x100 in cycle 1 -> imem_addr stays constant until ack; the acked fetch is discarded (instr_valid=0); the next imem_addr=0x100.
REQ-043 jump=1 with jump_target=0x200 and branch_taken=1 with branch_target=0x300 in the same HOLD cycle -> pc_out=0x200; then stall=0 -> imem_addr=0x200.
REQ-044 Jump to 0x103 -> misalign_err pulses for exactly one cycle and the fetch address is 0x100.
REQ-045 pc_out=0xFFFFFFFC with an ack and no redirect -> next pc_out=0x00000000.
REQ-046 imem_ack held 0 for MAX_WAIT cycles -> timeout_err=1, imem_req=0, state ERR; then rst=1 for one cycle -> timeout_err=0 and pc_out=RESET_PC.
